// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator: FSM state type,
// default 1024x768@60 timing (65 MHz pixel clock) and a line/frame total helper.
package video_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BP     = 160;
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 29;

  // Output coordinate port widths.
  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  // Total period of one axis (line in pixels or frame in lines).
  function automatic int unsigned timing_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_window_cnt.sv
// Wrapping position counter for one raster axis with region decode.
// cnt runs 0..TOTAL-1 while adv is high and wraps to 0; clr holds it at 0.
// active flags the visible region, sync flags [SYNC_START, SYNC_START+SYNC_LEN).
module sync_window_cnt
  import video_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP),
  parameter int unsigned ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
  parameter int unsigned SYNC_LEN   = DEF_H_SYNC,
  parameter int unsigned W          = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         active,
  output logic         sync
);

  // One extra bit so a sync window ending exactly at TOTAL still compares correctly.
  localparam int unsigned WE = W + 1;
  localparam logic [W-1:0]  LAST_C       = W'(TOTAL - 1);
  localparam logic [WE-1:0] ACTIVE_C     = WE'(ACTIVE);
  localparam logic [WE-1:0] SYNC_START_C = WE'(SYNC_START);
  localparam logic [WE-1:0] SYNC_END_C   = WE'(SYNC_START + SYNC_LEN);

  logic [WE-1:0] cnt_ext;

  // Position counter: cleared while idle, advances and wraps when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Region decode of the current position.
  always_comb begin
    cnt_ext = {1'b0, cnt};
    last    = (cnt == LAST_C);
    active  = (cnt_ext < ACTIVE_C);
    sync    = (cnt_ext >= SYNC_START_C) && (cnt_ext < SYNC_END_C);
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the display path (default 1024x768@60, 65 MHz).
// Produces registered hs/vs/de, pixel coordinates and frame/line strobes.
// Optional build macro TEST_PATTERN_EN adds a registered 8-bar colour pattern
// on rgb, aligned with de.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        line_start,
  output logic        busy
`ifdef TEST_PATTERN_EN
  ,
  output logic [23:0] rgb
`endif
);

  localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  state_t          state;
  logic            running;
  logic            frame_end;

  logic [HW-1:0]   h_cnt;
  logic            h_last, h_act, h_sync;
  logic [VW-1:0]   v_cnt;
  logic            v_last, v_act, v_sync;

  logic            de_n, hs_n, vs_n, fs_n, ls_n;
  logic [X_W-1:0]  x_n;
  logic [Y_W-1:0]  y_n;

  assign running   = (state != IDLE);
  assign frame_end = h_last && v_last;
  assign busy      = running;

  sync_window_cnt #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC),
    .W          (HW)
  ) u_h_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (!running),
    .adv    (running),
    .cnt    (h_cnt),
    .last   (h_last),
    .active (h_act),
    .sync   (h_sync)
  );

  // Vertical axis steps once per line, on the horizontal wrap.
  sync_window_cnt #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC),
    .W          (VW)
  ) u_v_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (!running),
    .adv    (running && h_last),
    .cnt    (v_cnt),
    .last   (v_last),
    .active (v_act),
    .sync   (v_sync)
  );

  // Run control: a started frame always completes; stopping is only honoured at its last pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= frame_end ? IDLE : DRAIN;
        DRAIN: begin
          if (en)             state <= RUN;
          else if (frame_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decode the current counter position into the values registered on the next edge.
  always_comb begin
    de_n = running && h_act && v_act;
    x_n  = de_n ? X_W'(h_cnt) : '0;
    y_n  = de_n ? Y_W'(v_cnt) : '0;
    hs_n = (running && h_sync) ? HS_POL : ~HS_POL;
    vs_n = (running && v_sync) ? VS_POL : ~VS_POL;
    fs_n = de_n && (h_cnt == '0) && (v_cnt == '0);
    ls_n = de_n && (h_cnt == '0);
  end

  // Output registers, one clock behind the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      hs          <= hs_n;
      vs          <= vs_n;
      de          <= de_n;
      x           <= x_n;
      y           <= y_n;
      frame_start <= fs_n;
      line_start  <= ls_n;
    end
  end

`ifdef TEST_PATTERN_EN
  // Eight vertical bars, 128 pixels wide, selected by x[9:7].
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Pattern register, aligned with de and black during blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb <= '0;
    end else begin
      rgb <= de_n ? bar_colour(x_n[9:7]) : '0;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a shrunk-timing instance checked cycle by cycle
// against a frame-position model, plus a default-timing instance checked over
// its first line against the 1024x768 figures.
module tb_video_timing_gen;

  // Shrunk timing for the model-checked instance.
  localparam int HA = 20, HFP = 3, HSY = 4, HBP = 5;
  localparam int VA = 6,  VFP = 2, VSY = 3, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic en_f = 1'b0;

  logic hs_s, vs_s, de_s, fs_s, ls_s, busy_s;
  logic [10:0] x_s;
  logic [9:0]  y_s;
  logic hs_f, vs_f, de_f, fs_f, ls_f, busy_f;
  logic [10:0] x_f;
  logic [9:0]  y_f;
`ifdef TEST_PATTERN_EN
  logic [23:0] rgb_s, rgb_f;
  localparam int VECW = 51;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`else
  localparam int VECW = 27;
`endif

  int checks = 0;
  int failures = 0;

  // Model state: running flag and linear position within the frame.
  int m_run = 0;
  int m_p = 0;
  int e_hs = 1, e_vs = 1, e_de = 0, e_x = 0, e_y = 0, e_fs = 0, e_ls = 0, e_busy = 0;

  logic [VECW-1:0] act_vec;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en),
    .hs(hs_s), .vs(vs_s), .de(de_s), .x(x_s), .y(y_s),
    .frame_start(fs_s), .line_start(ls_s), .busy(busy_s)
`ifdef TEST_PATTERN_EN
    , .rgb(rgb_s)
`endif
  );

  video_timing_gen dut_f (
    .clk(clk), .rst(rst), .en(en_f),
    .hs(hs_f), .vs(vs_f), .de(de_f), .x(x_f), .y(y_f),
    .frame_start(fs_f), .line_start(ls_f), .busy(busy_f)
`ifdef TEST_PATTERN_EN
    , .rgb(rgb_f)
`endif
  );

`ifdef TEST_PATTERN_EN
  assign act_vec = {hs_s, vs_s, de_s, x_s, y_s, fs_s, ls_s, busy_s, rgb_s};
`else
  assign act_vec = {hs_s, vs_s, de_s, x_s, y_s, fs_s, ls_s, busy_s};
`endif

  function automatic logic [VECW-1:0] exp_vec();
    logic [26:0] core;
    core = {e_hs[0], e_vs[0], e_de[0], 11'(e_x), 10'(e_y), e_fs[0], e_ls[0], e_busy[0]};
`ifdef TEST_PATTERN_EN
    return {core, (e_de != 0) ? bars[(e_x >> 7) & 7] : 24'h0};
`else
    return core;
`endif
  endfunction

  // Advance the model by one edge given the inputs sampled at that edge.
  task automatic model_step(input bit r, input bit e);
    int h, v;
    if (r) begin
      m_run = 0; m_p = 0;
      e_hs = 1; e_vs = 1; e_de = 0; e_x = 0; e_y = 0; e_fs = 0; e_ls = 0; e_busy = 0;
    end else begin
      h = m_p % HT;
      v = m_p / HT;
      e_de = (m_run != 0 && h < HA && v < VA) ? 1 : 0;
      e_x  = (e_de != 0) ? h : 0;
      e_y  = (e_de != 0) ? v : 0;
      e_hs = (m_run != 0 && h >= HA + HFP && h < HA + HFP + HSY) ? 0 : 1;
      e_vs = (m_run != 0 && v >= VA + VFP && v < VA + VFP + VSY) ? 0 : 1;
      e_fs = (e_de != 0 && m_p == 0) ? 1 : 0;
      e_ls = (e_de != 0 && h == 0) ? 1 : 0;
      if (m_run == 0) begin
        if (e) m_run = 1;
      end else if (m_p == FRAME - 1 && !e) begin
        m_run = 0; m_p = 0;
      end else begin
        m_p = (m_p + 1) % FRAME;
      end
      e_busy = m_run;
    end
  endtask

  task automatic tick();
    bit r, e;
    r = rst; e = en;
    @(posedge clk);
    model_step(r, e);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'($urandom_range(0, 1));
    tick(); tick();
    checks++;
    if (act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_small: got %h exp %h", act_vec, exp_vec());
    end
    checks++;
    if ({hs_f, vs_f, de_f, x_f, y_f, fs_f, ls_f, busy_f} !== {1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_full: got %b%b%b x=%0d y=%0d fs=%b ls=%b busy=%b exp hs=vs=1 rest 0",
               hs_f, vs_f, de_f, x_f, y_f, fs_f, ls_f, busy_f);
    end
  endtask

  task automatic test_first_frame();
    int f1 = -1, f2 = -1, de_cnt = 0, ls_cnt = 0;
    rst = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL first_frame_cycle%0d: got %h exp %h", i, act_vec, exp_vec());
      end
      if (fs_s === 1'b1) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
      if (f1 >= 0 && i < f1 + FRAME) begin
        de_cnt += int'(de_s === 1'b1);
        ls_cnt += int'(ls_s === 1'b1);
      end
    end
    checks++;
    if (f1 != 1) begin
      failures++;
      $display("FAIL first_de_latency: got %0d exp 1", f1);
    end
    checks++;
    if (f2 - f1 != FRAME) begin
      failures++;
      $display("FAIL frame_period: got %0d exp %0d", f2 - f1, FRAME);
    end
    checks++;
    if (de_cnt != HA * VA) begin
      failures++;
      $display("FAIL de_per_frame: got %0d exp %0d", de_cnt, HA * VA);
    end
    checks++;
    if (ls_cnt != VA) begin
      failures++;
      $display("FAIL line_starts: got %0d exp %0d", ls_cnt, VA);
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random_en_cycle%0d: got %h exp %h p=%0d", i, act_vec, exp_vec(), m_p);
      end
    end
  endtask

  task automatic test_drain();
    int p0, n, guard;
    en = 1'b1;
    p0 = 3 * HT + 7;
    guard = 0;
    while (!(m_run != 0 && m_p == p0) && guard < 3 * FRAME) begin
      tick(); guard++;
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL drain_lead: got %h exp %h", act_vec, exp_vec());
      end
    end
    en = 1'b0;
    n = 0;
    do begin
      tick(); n++;
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL drain_cycle%0d: got %h exp %h", n, act_vec, exp_vec());
      end
    end while (busy_s === 1'b1 && n < 2 * FRAME);
    checks++;
    if (n != FRAME - p0) begin
      failures++;
      $display("FAIL drain_length: got %0d exp %0d", n, FRAME - p0);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL idle_hold%0d: got %h exp %h", i, act_vec, exp_vec());
      end
    end
    en = 1'b1;
    tick(); tick();
    checks++;
    if ({fs_s, de_s, x_s, y_s} !== {1'b1, 1'b1, 11'd0, 10'd0}) begin
      failures++;
      $display("FAIL restart_origin: got fs=%b de=%b x=%0d y=%0d exp fs=1 de=1 x=0 y=0", fs_s, de_s, x_s, y_s);
    end
  endtask

  task automatic test_stop_at_last();
    int guard = 0;
    en = 1'b1;
    while (!(m_run != 0 && m_p == FRAME - 1) && guard < 3 * FRAME) begin
      tick(); guard++;
    end
    en = 1'b0;
    tick();
    checks++;
    if (busy_s !== 1'b0 || act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL stop_at_last: busy=%b got %h exp %h", busy_s, act_vec, exp_vec());
    end
    tick();
    checks++;
    if (de_s !== 1'b0 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL stop_at_last_idle: de=%b busy=%b exp 0 0", de_s, busy_s);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    en = 1'b1;
    n = $urandom_range(50, 2 * FRAME);
    for (int i = 0; i < n; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({hs_s, vs_s, de_s, x_s, y_s, busy_s} !== {1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0}) begin
      failures++;
      $display("FAIL midframe_reset: got hs=%b vs=%b de=%b x=%0d y=%0d busy=%b exp 1 1 0 0 0 0",
               hs_s, vs_s, de_s, x_s, y_s, busy_s);
    end
    rst = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL after_reset_cycle%0d: got %h exp %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_full_timing();
    bit xd, xh, xl;
    int xx, xy;
    en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en_f = 1'b1;
    tick();
    checks++;
    if (busy_f !== 1'b1 || de_f !== 1'b0) begin
      failures++;
      $display("FAIL full_run_entry: busy=%b de=%b exp 1 0", busy_f, de_f);
    end
    for (int i = 0; i <= 1344; i++) begin
      tick();
      xd = (i < 1024) || (i == 1344);
      xh = !(i >= 1048 && i < 1184);
      xl = (i == 0) || (i == 1344);
      xx = (i < 1024) ? i : 0;
      xy = (i == 1344) ? 1 : 0;
      checks++;
      if ({de_f, hs_f, vs_f, ls_f, fs_f, x_f, y_f} !==
          {xd, xh, 1'b1, xl, (i == 0), 11'(xx), 10'(xy)}) begin
        failures++;
        $display("FAIL full_line_i%0d: got de=%b hs=%b vs=%b ls=%b fs=%b x=%0d y=%0d exp de=%b hs=%b vs=1 ls=%b fs=%b x=%0d y=%0d",
                 i, de_f, hs_f, vs_f, ls_f, fs_f, x_f, y_f, xd, xh, xl, (i == 0), xx, xy);
      end
`ifdef TEST_PATTERN_EN
      if (i == 0 || i == 128 || i == 1023 || i == 1100) begin
        checks++;
        if (rgb_f !== ((i == 0) ? 24'hFFFFFF : (i == 128) ? 24'hFFFF00 : 24'h000000)) begin
          failures++;
          $display("FAIL full_rgb_i%0d: got %h", i, rgb_f);
        end
      end
`endif
    end
    en_f = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_random_en();
    test_drain();
    test_stop_at_last();
    test_reset_midframe();
    test_full_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
